// File: rtl/kart_net_pkg.sv
// kart_net_pkg: constants and types shared by the kart link packer and unpacker.
// Holds the packet layout (byte indices, length, header) and the TX state type.
package kart_net_pkg;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
   localparam int         GAP_DEFAULT    = 4;
   localparam int         PKT_LEN        = 10;

   localparam logic [3:0] IDX_HDR  = 4'd0;
   localparam logic [3:0] IDX_SEQ  = 4'd1;
   localparam logic [3:0] IDX_XH   = 4'd2;
   localparam logic [3:0] IDX_XL   = 4'd3;
   localparam logic [3:0] IDX_YH   = 4'd4;
   localparam logic [3:0] IDX_YL   = 4'd5;
   localparam logic [3:0] IDX_DH   = 4'd6;
   localparam logic [3:0] IDX_DL   = 4'd7;
   localparam logic [3:0] IDX_GAME = 4'd8;
   localparam logic [3:0] IDX_CSUM = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/kart_state_tx.sv
// kart_state_tx: packs local player state into a 10-byte packet streamed as bytes.
// Ports: clk, btnc (sync reset), send_tick, player_x/y, player_direction,
//   game_stat, axioready in; axiov, axiod, axiol, busy out.
module kart_state_tx
   import kart_net_pkg::*;
#(
   parameter logic [7:0] HEADER     = HEADER_DEFAULT,
   parameter int         GAP_CYCLES = GAP_DEFAULT
) (
   input  logic        clk,
   input  logic        btnc,
   input  logic        send_tick,
   input  logic [10:0] player_x,
   input  logic [10:0] player_y,
   input  logic [8:0]  player_direction,
   input  logic [2:0]  game_stat,
   input  logic        axioready,
   output logic        axiov,
   output logic [7:0]  axiod,
   output logic        axiol,
   output logic        busy
);

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   tx_state_t   state;
   tx_state_t   state_nx;

   logic [3:0]  idx;
   logic [7:0]  seq;
   logic [7:0]  csum;
   logic [7:0]  gcnt;
   logic        pending;

   logic [10:0] snap_x;
   logic [10:0] snap_y;
   logic [8:0]  snap_dir;
   logic [2:0]  snap_game;

   logic [15:0] x16;
   logic [15:0] y16;
   logic [15:0] d16;
   logic [7:0]  byte_cur;

   logic        start;
   logic        last;
   logic        xfer;

   assign x16   = {5'b0, snap_x};
   assign y16   = {5'b0, snap_y};
   assign d16   = {7'b0, snap_dir};

   // A merged request waiting in pending is served like a fresh tick.
   assign start = (state == IDLE) && (send_tick || pending);
   assign last  = (idx == IDX_CSUM);
   assign xfer  = axiov && axioready;

   always_comb begin
      byte_cur = 8'h00;
      unique case (idx)
         IDX_HDR:  byte_cur = HEADER;
         IDX_SEQ:  byte_cur = seq;
         IDX_XH:   byte_cur = x16[15:8];
         IDX_XL:   byte_cur = x16[7:0];
         IDX_YH:   byte_cur = y16[15:8];
         IDX_YL:   byte_cur = y16[7:0];
         IDX_DH:   byte_cur = d16[15:8];
         IDX_DL:   byte_cur = d16[7:0];
         IDX_GAME: byte_cur = {5'b0, snap_game};
         IDX_CSUM: byte_cur = csum;
         default:  byte_cur = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (btnc) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      axiov    = 1'b0;
      axiod    = 8'h00;
      axiol    = 1'b0;
      busy     = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start) state_nx = SEND;
         end
         SEND: begin
            axiov = 1'b1;
            axiod = byte_cur;
            axiol = last;
            if (axioready && last) state_nx = GAP;
         end
         GAP: begin
            if (gcnt == GAP_LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (btnc) begin
         idx       <= 4'd0;
         seq       <= 8'd0;
         csum      <= 8'd0;
         gcnt      <= 8'd0;
         pending   <= 1'b0;
         snap_x    <= 11'd0;
         snap_y    <= 11'd0;
         snap_dir  <= 9'd0;
         snap_game <= 3'd0;
      end else begin
         if (send_tick && (state != IDLE)) pending <= 1'b1;

         if (start) begin
            pending   <= 1'b0;
            idx       <= 4'd0;
            csum      <= 8'd0;
            snap_x    <= player_x;
            snap_y    <= player_y;
            snap_dir  <= player_direction;
            snap_game <= game_stat;
         end

         // Checksum accumulates each byte as it leaves, ready for byte 9.
         if (xfer) begin
            idx <= idx + 4'd1;
            if (last) begin
               seq <= seq + 8'd1;
            end else begin
               csum <= csum ^ byte_cur;
            end
         end

         if (state == GAP) begin
            gcnt <= gcnt + 8'd1;
         end else begin
            gcnt <= 8'd0;
         end
      end
   end

endmodule
